// File: rtl/rf_pkg.sv
// Types shared by the reg32 writeback arbiter and its request FIFOs.
// A request pairs a destination register index with the data to write.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef struct packed {
    logic [RF_AW-1:0] wn;
    logic [RF_DW-1:0] d;
  } rf_wr_t;

  // r0 is hardwired to zero, so a request aimed at it is consumed but never written
  function automatic logic rf_wr_commits(input rf_wr_t w);
    return (w.wn != {RF_AW{1'b0}});
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Valid/ready write-request channel from one writeback source into the arbiter.
interface rf_write_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          valid;
  logic          ready;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;

  modport master (output valid, output wn, output d, input ready);
  modport slave  (input valid, input wn, input d, output ready);

endinterface

// File: rtl/rf_wr_fifo.sv
// Small circular FIFO of register-write requests, one per writeback source.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic                   pop,
  input  rf_wr_t                 din,
  output rf_wr_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  rf_wr_t        mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage, cleared on reset so no stale request can ever surface
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {($bits(rf_wr_t)){1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count carries one extra bit to tell full from empty
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single reg32 write port between ALU (port 0)
// and load (port 1) writeback; the registered we/wn/d drive reg32 directly.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                clrn,
  rf_write_arbiter_if.slave   in0,
  rf_write_arbiter_if.slave   in1,
  output logic                we,
  output logic [AW-1:0]       wn,
  output logic [DW-1:0]       d,
  output logic                idle
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  rf_wr_t        din0_s;
  rf_wr_t        din1_s;
  rf_wr_t        head0_s;
  rf_wr_t        head1_s;
  rf_wr_t        gnt_head_s;
  logic          full0_s;
  logic          full1_s;
  logic          empty0_s;
  logic          empty1_s;
  logic          push0_s;
  logic          push1_s;
  logic          pop0_s;
  logic          pop1_s;
  logic [CW-1:0] cnt0_s;
  logic [CW-1:0] cnt1_s;
  logic          gnt_s;
  logic          gnt_sel_s;
  logic          last_grant_r;
  logic          we_r;
  logic [AW-1:0] wn_r;
  logic [DW-1:0] d_r;

  // ready depends on registered occupancy only, so a full FIFO refuses a push even while popped
  assign in0.ready = (cnt0_s < CNT_DEPTH);
  assign in1.ready = (cnt1_s < CNT_DEPTH);
  assign push0_s   = in0.valid & ~full0_s;
  assign push1_s   = in1.valid & ~full1_s;
  assign din0_s    = {in0.wn, in0.d};
  assign din1_s    = {in1.wn, in1.d};

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push0_s),
    .pop   (pop0_s),
    .din   (din0_s),
    .head  (head0_s),
    .full  (full0_s),
    .empty (empty0_s),
    .count (cnt0_s)
  );

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push1_s),
    .pop   (pop1_s),
    .din   (din1_s),
    .head  (head1_s),
    .full  (full1_s),
    .empty (empty1_s),
    .count (cnt1_s)
  );

  // Round-robin grant: under contention the port not granted last time wins
  always_comb begin
    gnt_s     = 1'b1;
    gnt_sel_s = 1'b0;
    if (!empty0_s && !empty1_s) begin
      gnt_sel_s = ~last_grant_r;
    end else if (!empty0_s) begin
      gnt_sel_s = 1'b0;
    end else if (!empty1_s) begin
      gnt_sel_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
  end

  assign pop0_s     = gnt_s & ~gnt_sel_s;
  assign pop1_s     = gnt_s & gnt_sel_s;
  assign gnt_head_s = gnt_sel_s ? head1_s : head0_s;

  // Write-port register and grant history; wn/d hold when nothing is granted
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      we_r         <= 1'b0;
      wn_r         <= {AW{1'b0}};
      d_r          <= {DW{1'b0}};
      last_grant_r <= 1'b1;
    end else if (gnt_s) begin
      we_r         <= rf_wr_commits(gnt_head_s);
      wn_r         <= gnt_head_s.wn;
      d_r          <= gnt_head_s.d;
      last_grant_r <= gnt_sel_s;
    end else begin
      we_r         <= 1'b0;
    end
  end

  assign we   = we_r;
  assign wn   = wn_r;
  assign d    = d_r;
  assign idle = empty0_s & empty1_s & ~we_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a cycle-level reference model pushes
// expected write-port states into a scoreboard, popped after each clock edge.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic             we;
    logic [RF_AW-1:0] wn;
    logic [RF_DW-1:0] d;
    logic             idle;
  } exp_t;

  logic             clk  = 1'b0;
  logic             clrn = 1'b0;
  logic             we;
  logic [RF_AW-1:0] wn;
  logic [RF_DW-1:0] d;
  logic             idle;

  rf_write_arbiter_if #(.AW(RF_AW), .DW(RF_DW)) in0 ();
  rf_write_arbiter_if #(.AW(RF_AW), .DW(RF_DW)) in1 ();

  rf_write_arbiter #(.DW(RF_DW), .AW(RF_AW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .clrn (clrn),
    .in0  (in0),
    .in1  (in1),
    .we   (we),
    .wn   (wn),
    .d    (d),
    .idle (idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wr_t q0[$];
  rf_wr_t q1[$];
  exp_t   exp_q[$];
  logic             m_we;
  logic             m_last;
  logic [RF_AW-1:0] m_wn;
  logic [RF_DW-1:0] m_d;

  function automatic rf_wr_t mk(input logic [RF_AW-1:0] w, input logic [RF_DW-1:0] v);
    return {w, v};
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    exp_q.delete();
    m_we   = 1'b0;
    m_wn   = '0;
    m_d    = '0;
    m_last = 1'b1;
  endtask

  // Drives one cycle of requests, advances the reference model, queues the expectation
  task automatic drive_cycle(input logic v0, input rf_wr_t p0, input logic v1, input rf_wr_t p1);
    logic   acc0, acc1, g, sel;
    rf_wr_t h;
    exp_t   e;
    in0.valid = v0; in0.wn = p0.wn; in0.d = p0.d;
    in1.valid = v1; in1.wn = p1.wn; in1.d = p1.d;
    acc0 = v0 && (q0.size() < DEPTH);
    acc1 = v1 && (q1.size() < DEPTH);
    g = 1'b1;
    sel = 1'b0;
    if (q0.size() != 0 && q1.size() != 0) sel = ~m_last;
    else if (q0.size() != 0) sel = 1'b0;
    else if (q1.size() != 0) sel = 1'b1;
    else g = 1'b0;
    if (g) begin
      h = sel ? q1.pop_front() : q0.pop_front();
      m_we = (h.wn != 5'd0);
      m_wn = h.wn;
      m_d = h.d;
      m_last = sel;
    end else begin
      m_we = 1'b0;
    end
    if (acc0) q0.push_back(p0);
    if (acc1) q1.push_back(p1);
    e.we = m_we; e.wn = m_wn; e.d = m_d;
    e.idle = (q0.size() == 0) && (q1.size() == 0) && !m_we;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({we, wn, d, idle} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_out got we=%b wn=%0d d=%h idle=%b want 0/0/0/1", we, wn, d, idle);
    end
    n_tests++;
    if ({in0.ready, in1.ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready got %b%b want 11", in0.ready, in1.ready);
    end
    #11 clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    exp_t e;
    int i0 = 0, i1 = 0, k = 0;
    logic a0, a1;
    logic [RF_DW-1:0] want;
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if ({in0.ready, in1.ready} !== {q0.size() < DEPTH, q1.size() < DEPTH}) begin
        n_fail++;
        $display("FAIL cont_ready[%0d] got %b%b want %b%b", c, in0.ready, in1.ready,
                 q0.size() < DEPTH, q1.size() < DEPTH);
      end
      a0 = (q0.size() < DEPTH);
      a1 = (q1.size() < DEPTH);
      drive_cycle(1'b1, mk(5'(1 + i0), 32'h100 + 32'(i0)), 1'b1, mk(5'(17 + i1), 32'h200 + 32'(i1)));
      if (a0) i0++;
      if (a1) i1++;
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL cont_sb[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
      if (c == 1) begin
        n_tests++;
        if ({in0.ready, in1.ready} !== 2'b10) begin
          n_fail++;
          $display("FAIL cont_full1 got %b%b want 10", in0.ready, in1.ready);
        end
      end
      if (c >= 1) begin
        want = ((k % 2) == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2);
        n_tests++;
        if ({we, d} !== {1'b1, want}) begin
          n_fail++;
          $display("FAIL cont_alt[%0d] got we=%b d=%h want we=1 d=%h", k, we, d, want);
        end
        k++;
      end
    end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b0, mk(5'd0, 32'd0));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL cont_drain[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
    end
  endtask

  task automatic test_single_port();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive_cycle(1'b1, mk(5'd5, 32'hDEADBEEF), 1'b0, mk(5'd0, 32'd0));
      else        drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b0, mk(5'd0, 32'd0));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL single_sb[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
      if (c == 1) begin
        n_tests++;
        if ({we, wn, d} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
          n_fail++;
          $display("FAIL single_k1 got we=%b wn=%0d d=%h want 1/5/deadbeef", we, wn, d);
        end
      end
      if (c == 2) begin
        n_tests++;
        if ({we, idle} !== 2'b01) begin
          n_fail++;
          $display("FAIL single_k2 got we=%b idle=%b want 0/1", we, idle);
        end
      end
    end
  endtask

  task automatic test_r0_drop();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b1, mk(5'd0, 32'h1234));
      else if (c == 1) drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b1, mk(5'd13, 32'h5678));
      else             drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b0, mk(5'd0, 32'd0));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL r0_sb[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
      if (c == 1) begin
        n_tests++;
        if ({we, wn, d} !== {1'b0, 5'd0, 32'h1234}) begin
          n_fail++;
          $display("FAIL r0_drop got we=%b wn=%0d d=%h want 0/0/1234", we, wn, d);
        end
      end
      if (c == 2) begin
        n_tests++;
        if ({we, wn, d} !== {1'b1, 5'd13, 32'h5678}) begin
          n_fail++;
          $display("FAIL r0_next got we=%b wn=%0d d=%h want 1/13/5678", we, wn, d);
        end
      end
    end
  endtask

  task automatic test_full_boundary();
    exp_t e;
    int i0 = 0;
    logic full_seen = 1'b0;
    logic a0;
    rf_wr_t p0;
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if ({in0.ready, in1.ready} !== {q0.size() < DEPTH, q1.size() < DEPTH}) begin
        n_fail++;
        $display("FAIL full_ready[%0d] got %b%b want %b%b", c, in0.ready, in1.ready,
                 q0.size() < DEPTH, q1.size() < DEPTH);
      end
      if (in0.ready === 1'b0) full_seen = 1'b1;
      a0 = (q0.size() < DEPTH);
      p0 = a0 ? mk(5'd7, 32'h400 + 32'(i0)) : mk(5'd7, 32'hBAD00000 + 32'(c));
      drive_cycle(1'b1, p0, 1'b1, mk(5'd20, 32'h300 + 32'(c)));
      if (a0) i0++;
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL full_sb[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
      n_tests++;
      if (we === 1'b1 && d[31:16] === 16'hBAD0) begin
        n_fail++;
        $display("FAIL full_refused[%0d] got d=%h want no refused push on the port", c, d);
      end
    end
    n_tests++;
    if (full_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reached got %b want 1", full_seen);
    end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b0, mk(5'd0, 32'd0));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL full_drain[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, mk(5'd9, 32'h500 + 32'(c)), 1'b1, mk(5'd10, 32'h600 + 32'(c)));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL mid_pre[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
    end
    in0.valid = 1'b0;
    in1.valid = 1'b0;
    #2 clrn = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({we, wn, d, idle, in0.ready, in1.ready} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset got we=%b wn=%0d d=%h idle=%b rdy=%b%b want 0/0/0/1/11",
               we, wn, d, idle, in0.ready, in1.ready);
    end
    @(posedge clk);
    #1 clrn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, mk(5'd0, 32'd0), 1'b0, mk(5'd0, 32'd0));
      e = exp_q.pop_front();
      n_tests++;
      if ({we, wn, d, idle} !== {e.we, e.wn, e.d, e.idle}) begin
        n_fail++;
        $display("FAIL mid_post[%0d] got we=%b wn=%0d d=%h idle=%b want we=%b wn=%0d d=%h idle=%b",
                 c, we, wn, d, idle, e.we, e.wn, e.d, e.idle);
      end
    end
  endtask

  initial begin
    in0.valid = 1'b0; in0.wn = '0; in0.d = '0;
    in1.valid = 1'b0; in1.wn = '0; in1.d = '0;
    model_reset();
    test_reset();
    test_contention();
    test_single_port();
    test_r0_drop();
    test_full_boundary();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
